// File: rtl/alu.sv
// 16-bit registered integer ALU for the CPU execute stage.
// Results, branch condition and status flags appear one cycle after issue.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_code,
    input  logic [WIDTH-1:0] reg_data1,
    input  logic [WIDTH-1:0] reg_data2,
    output logic [WIDTH-1:0] accum,
    output logic             branch_check,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SW-1:0]    shamt;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] res_n;
    logic             br_n;
    logic             cy_n;
    logic             ov_n;

    assign sum   = {1'b0, reg_data1} + {1'b0, reg_data2};
    assign diff  = {1'b0, reg_data1} - {1'b0, reg_data2};
    assign shamt = reg_data2[SW-1:0];
    assign lt_s  = $signed(reg_data1) < $signed(reg_data2);
    // The top bit of the widened difference is the borrow, i.e. unsigned A < B.
    assign lt_u  = diff[WIDTH];

    assign add_ovf = (reg_data1[WIDTH-1] == reg_data2[WIDTH-1])
                   && (sum[WIDTH-1] != reg_data1[WIDTH-1]);
    assign sub_ovf = (reg_data1[WIDTH-1] != reg_data2[WIDTH-1])
                   && (diff[WIDTH-1] != reg_data1[WIDTH-1]);

    always_comb begin
        res_n = '0;
        br_n  = 1'b0;
        cy_n  = 1'b0;
        ov_n  = 1'b0;
        case (alu_code)
            4'b0000: res_n = reg_data1 & reg_data2;
            4'b0001: res_n = reg_data1 | reg_data2;
            4'b0010: res_n = reg_data1 ^ reg_data2;
            4'b0011: res_n = ~reg_data1;
            4'b0100: begin
                res_n = diff[WIDTH-1:0];
                cy_n  = lt_u;
                ov_n  = sub_ovf;
            end
            4'b0101: res_n = reg_data1 << shamt;
            4'b0110: res_n = reg_data1 >> shamt;
            4'b0111: res_n = $signed(reg_data1) >>> shamt;
            4'b1000: begin
                res_n = sum[WIDTH-1:0];
                cy_n  = sum[WIDTH];
                ov_n  = add_ovf;
            end
            4'b1001: res_n = {{(WIDTH-1){1'b0}}, lt_s};
            4'b1010: res_n = {{(WIDTH-1){1'b0}}, lt_u};
            4'b1011: res_n = reg_data2;
            default: begin
                // Branch codes also publish A - B and the subtract flags.
                res_n = diff[WIDTH-1:0];
                cy_n  = lt_u;
                ov_n  = sub_ovf;
                case (alu_code[1:0])
                    2'b00:   br_n = (reg_data1 == reg_data2);
                    2'b01:   br_n = (reg_data1 != reg_data2);
                    2'b10:   br_n = lt_s;
                    default: br_n = ~lt_s;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accum         <= '0;
            branch_check  <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            accum         <= res_n;
            branch_check  <= br_n;
            zero_flag     <= (res_n == '0);
            carry_flag    <= cy_n;
            overflow_flag <= ov_n;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed checks of alu against an arithmetic reference model.
// Flags are packed as {branch, zero, carry, overflow}.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_code;
    logic [15:0] reg_data1;
    logic [15:0] reg_data2;
    logic [15:0] accum;
    logic        branch_check;
    logic        zero_flag;
    logic        carry_flag;
    logic        overflow_flag;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_code(alu_code),
        .reg_data1(reg_data1),
        .reg_data2(reg_data2),
        .accum(accum),
        .branch_check(branch_check),
        .zero_flag(zero_flag),
        .carry_flag(carry_flag),
        .overflow_flag(overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Returns {accum, branch, zero, carry, overflow} from plain integer math.
    function automatic logic [19:0] model(input logic [3:0] c,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        int ua, ub, sa, sb, r, d, pw;
        bit br, cy, ov;
        logic [15:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        pw = 1 << (ub % 16);
        r = 0; br = 0; cy = 0; ov = 0;
        case (c)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd2:  r = ua ^ ub;
            4'd3:  r = 65535 - ua;
            4'd5:  r = (ua * pw) % 65536;
            4'd6:  r = ua / pw;
            4'd7:  r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
            4'd8: begin
                r  = ua + ub;
                cy = (r > 65535);
                d  = sa + sb;
                ov = (d > 32767) || (d < -32768);
            end
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
            4'd11: r = ub;
            default: begin
                r  = ua - ub;
                cy = (ua < ub);
                d  = sa - sb;
                ov = (d > 32767) || (d < -32768);
                if (c == 4'd12) br = (ua == ub);
                if (c == 4'd13) br = (ua != ub);
                if (c == 4'd14) br = (sa < sb);
                if (c == 4'd15) br = (sa >= sb);
            end
        endcase
        res = r[15:0];
        return {res, br, (res == 16'h0), cy, ov};
    endfunction

    task automatic issue(input string tag, input logic [3:0] c,
                         input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        @(negedge clk);
        alu_code  = c;
        reg_data1 = a;
        reg_data2 = b;
        e = model(c, a, b);
        @(posedge clk);
        #1;
        check({tag, ".accum"}, 32'(accum), 32'(e[19:4]));
        check({tag, ".flags"},
              32'({branch_check, zero_flag, carry_flag, overflow_flag}),
              32'(e[3:0]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".accum"}, 32'(accum), 32'h0);
        check({tag, ".flags"},
              32'({branch_check, zero_flag, carry_flag, overflow_flag}),
              32'h0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        alu_code  = 4'b1000;
        reg_data1 = 16'd5;
        reg_data2 = 16'd5;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release.accum", 32'(accum), 32'h000A);

        issue("add1", 4'b1000, 16'h0001, 16'h003F);
        check("add1.const", 32'(accum), 32'h0040);
        issue("sub1", 4'b0100, 16'h003F, 16'h0001);
        check("sub1.const", 32'(accum), 32'h003E);
        issue("sub2", 4'b0100, 16'h0001, 16'h0003);
        check("sub2.const", 32'({accum, carry_flag}), 32'h1FFFD);
        issue("addov", 4'b1000, 16'h7FFF, 16'h0001);
        check("addov.const",
              32'({accum, carry_flag, overflow_flag}), 32'h20001);
        issue("addcy", 4'b1000, 16'hFFFF, 16'h0001);
        check("addcy.const",
              32'({accum, zero_flag, carry_flag}), 32'h00003);
        issue("beq1", 4'b1100, 16'h0001, 16'h0001);
        check("beq1.const", 32'({branch_check, zero_flag}), 32'h3);
        issue("beq0", 4'b1100, 16'h0001, 16'h0003);
        check("beq0.const", 32'(branch_check), 32'h0);
        issue("bne13", 4'b1101, 16'h0001, 16'h0003);
        issue("bne31", 4'b1101, 16'h0003, 16'h0001);
        issue("bne22", 4'b1101, 16'h0002, 16'h0002);
        check("bne22.const", 32'(branch_check), 32'h0);
        issue("blt13", 4'b1110, 16'h0001, 16'h0003);
        check("blt13.const", 32'(branch_check), 32'h1);
        issue("blt31", 4'b1110, 16'h0003, 16'h0001);
        issue("bltneg", 4'b1110, 16'hFFFF, 16'h0001);
        check("bltneg.const", 32'(branch_check), 32'h1);
        issue("bge", 4'b1111, 16'h0001, 16'hFFFF);
        check("bge.const", 32'(branch_check), 32'h1);
        issue("and", 4'b0000, 16'h0F0F, 16'h00FF);
        check("and.const", 32'(accum), 32'h000F);
        issue("shl", 4'b0101, 16'h0001, 16'h0013);
        check("shl.const", 32'(accum), 32'h0008);
        issue("sra", 4'b0111, 16'h8000, 16'h000F);
        check("sra.const", 32'(accum), 32'hFFFF);
        issue("shr", 4'b0110, 16'h8000, 16'h000F);
        check("shr.const", 32'(accum), 32'h0001);
        issue("shl0", 4'b0101, 16'hA5C3, 16'hFFF0);
        issue("slt", 4'b1001, 16'h8000, 16'h0001);
        issue("sltu", 4'b1010, 16'h8000, 16'h0001);
        issue("not", 4'b0011, 16'h1234, 16'hFFFF);
        issue("mov", 4'b1011, 16'h1234, 16'hBEEF);

        // Mid-stream reset discards the pending result.
        @(negedge clk);
        alu_code  = 4'b1011;
        reg_data2 = 16'h5555;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            issue("rand", 4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
